fb_board_painter: RTL and testbench

// - Write-side producer for the 24-bit 640x480 framebuffer 2-port RAM.
// - The VGA RGB reader scans that RAM linearly (addr = y*640+x).
// - On a start pulse, sweeps every pixel once and writes its colour:
//   - background outside the board;
//   - 8x8 light/dark chess squares;
//   - piece sprites fetched from an external 1-bit mask ROM.
// - Runs on vga_clk and feeds the RAM write port directly.

---
 rtl/fb_board_painter_if.sv | 24 ++
 rtl/fb_board_painter.sv | 200 ++++++++++++++++++++
 tb/tb_fb_board_painter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_board_painter_if.sv
// Connection bundle between the board painter, its control source, the sprite mask ROM and the
// framebuffer RAM write port.
interface fb_board_painter_if;
  logic         start;
  logic [255:0] board;
  logic [5:0]   cursor_sq;
  logic [14:0]  sprite_addr;
  logic         sprite_data;
  logic         wr_en;
  logic [18:0]  wr_addr;
  logic [23:0]  wr_data;
  logic         busy;
  logic         done;

  modport master (
    input  start, board, cursor_sq, sprite_data,
    output sprite_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, board, cursor_sq, sprite_data,
    input  sprite_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/fb_board_painter.sv
// Sweeps the framebuffer once per start pulse, painting background, chess squares and sprites.
// Optional cursor ring on the selected square when CURSOR_HIGHLIGHT_EN is defined.
module fb_board_painter #(
  parameter int unsigned ScreenWidth  = 640,
  parameter int unsigned ScreenHeight = 480,
  parameter int unsigned BoardX0      = 80,
  parameter int unsigned SqSize       = 60,
  parameter logic [23:0] BgColor      = 24'h202020,
  parameter logic [23:0] LightSq      = 24'hEEEED2,
  parameter logic [23:0] DarkSq       = 24'h769656,
  parameter logic [23:0] WhitePc      = 24'hFFFFFF,
  parameter logic [23:0] BlackPc      = 24'h000000,
  parameter logic [23:0] HlColor      = 24'hF6F669
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  fb_board_painter_if.master fb_io
);
  localparam logic [9:0] XLast   = 10'(ScreenWidth - 1);
  localparam logic [8:0] YLast   = 9'(ScreenHeight - 1);
  localparam logic [9:0] XBoard0 = 10'(BoardX0);
  localparam logic [9:0] XBoard1 = 10'(BoardX0 + 8 * SqSize);
  localparam logic [5:0] PLast   = 6'(SqSize - 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrainA, StDrainB, StDone} state_e;

  state_e       state_q, state_d;
  logic [9:0]   x_q, x_d;
  logic [8:0]   y_q, y_d;
  logic [2:0]   col_q, col_d, row_q, row_d;
  logic [5:0]   px_q, px_d, py_q, py_d;
  logic [18:0]  pix_addr_q, pix_addr_d;
  logic [255:0] board_q;
  logic         accept, in_board, last_pix;

  assign accept   = (state_q == StIdle) && fb_io.start;
  assign in_board = (x_q >= XBoard0) && (x_q < XBoard1);
  assign last_pix = (x_q == XLast) && (y_q == YLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fb_io.start) state_d = StRun;
      StRun:    if (last_pix) state_d = StDrainA;
      StDrainA: state_d = StDrainB;
      StDrainB: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Board-relative counters only advance inside the board and restart at every line wrap.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    col_d      = col_q;
    row_d      = row_q;
    px_d       = px_q;
    py_d       = py_q;
    pix_addr_d = pix_addr_q;
    if (accept) begin
      x_d        = '0;
      y_d        = '0;
      col_d      = '0;
      row_d      = '0;
      px_d       = '0;
      py_d       = '0;
      pix_addr_d = '0;
    end else if (state_q == StRun) begin
      pix_addr_d = last_pix ? '0 : pix_addr_q + 19'd1;
      if (x_q == XLast) begin
        x_d   = '0;
        px_d  = '0;
        col_d = '0;
        if (y_q == YLast) begin
          y_d   = '0;
          py_d  = '0;
          row_d = '0;
        end else begin
          y_d = y_q + 9'd1;
          if (py_q == PLast) begin
            py_d  = '0;
            row_d = row_q + 3'd1;
          end else begin
            py_d = py_q + 6'd1;
          end
        end
      end else begin
        x_d = x_q + 10'd1;
        if (in_board) begin
          if (px_q == PLast) begin
            px_d  = '0;
            col_d = col_q + 3'd1;
          end else begin
            px_d = px_q + 6'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      pix_addr_q <= '0;
      board_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pix_addr_q <= pix_addr_d;
      if (accept) board_q <= fb_io.board;
    end
  end

  // S0: piece lookup and sprite fetch for the pixel at the counters.
  logic [3:0] code;
  logic [2:0] ptype;
  logic       hl_s0;

  assign code              = board_q[{row_q, col_q, 2'b00} +: 4];
  assign ptype             = code[2:0];
  assign fb_io.sprite_addr = (state_q == StRun) ? {ptype - 3'd1, py_q, px_q} : '0;

`ifdef CURSOR_HIGHLIGHT_EN
  localparam logic [5:0] HlLo = 6'd3;
  localparam logic [5:0] HlHi = 6'(SqSize - 4);
  logic [5:0] cursor_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) cursor_q <= '0;
    else if (accept) cursor_q <= fb_io.cursor_sq;
  end

  assign hl_s0 = ({row_q, col_q} == cursor_q) &&
                 (px_q < HlLo || px_q > HlHi || py_q < HlLo || py_q > HlHi);
`else
  logic unused_cursor;
  assign unused_cursor = ^fb_io.cursor_sq;
  assign hl_s0         = 1'b0;
`endif

  // S1: sprite bit is now valid; pick the colour and register the RAM write.
  logic        s1_valid_q, s1_outside_q, s1_piece_q, s1_black_q, s1_light_q, s1_hl_q;
  logic [18:0] s1_addr_q;
  logic        wr_en_q;
  logic [18:0] wr_addr_q;
  logic [23:0] wr_data_q, colour;

  always_comb begin
    colour = s1_light_q ? LightSq : DarkSq;
    if (s1_outside_q) colour = BgColor;
    else if (s1_piece_q && fb_io.sprite_data) colour = s1_black_q ? BlackPc : WhitePc;
    else if (s1_hl_q) colour = HlColor;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_outside_q <= 1'b0;
      s1_piece_q   <= 1'b0;
      s1_black_q   <= 1'b0;
      s1_light_q   <= 1'b0;
      s1_hl_q      <= 1'b0;
      s1_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      s1_valid_q   <= (state_q == StRun);
      s1_outside_q <= !in_board;
      s1_piece_q   <= (ptype != 3'd0);
      s1_black_q   <= code[3];
      s1_light_q   <= !(row_q[0] ^ col_q[0]);
      s1_hl_q      <= hl_s0;
      s1_addr_q    <= pix_addr_q;
      wr_en_q      <= s1_valid_q;
      if (s1_valid_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= colour;
      end
    end
  end

  assign fb_io.wr_en   = wr_en_q;
  assign fb_io.wr_addr = wr_addr_q;
  assign fb_io.wr_data = wr_data_q;
  assign fb_io.busy    = (state_q == StRun) || (state_q == StDrainA) || (state_q == StDrainB);
  assign fb_io.done    = (state_q == StDone);
endmodule

// File: tb/tb_fb_board_painter.sv
// Bench for fb_board_painter on a reduced screen geometry, checked against a pixel-level model.
module tb_fb_board_painter;
  localparam int W   = 112;
  localparam int H   = 80;
  localparam int BX0 = 16;
  localparam int SQ  = 10;
  localparam int NPIX = W * H;
  localparam logic [23:0] BG = 24'h202020, LIGHT = 24'hEEEED2, DARK = 24'h769656;
  localparam logic [23:0] WHITE = 24'hFFFFFF, BLACK = 24'h000000, HL = 24'hF6F669;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fb_board_painter_if fb_if ();

  fb_board_painter #(
    .ScreenWidth (W),
    .ScreenHeight(H),
    .BoardX0     (BX0),
    .SqSize      (SQ)
  ) dut (
    .vga_clk(clk),
    .reset_n(reset_n),
    .fb_io  (fb_if)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  int          wr_total = 0;
  int          rom_mode = 0;
  logic [31:0] rom_seed = 32'h0;
  logic [14:0] rom_hit = 15'h0;
  exp_t        exp_q[$];
  logic [23:0] fb_mem[NPIX];
  logic        prev_wr_en = 1'b0;

  function automatic logic rom_bit(input logic [14:0] a);
    logic [31:0] h;
    if (rom_mode == 0) return a == rom_hit;
    h = ({17'd0, a} ^ rom_seed) * 32'h9E3779B1;
    return h[20];
  endfunction

  always @(posedge clk) fb_if.sprite_data <= rom_bit(fb_if.sprite_addr);

  function automatic logic [23:0] ref_pixel(input logic [255:0] b, input logic [5:0] cur,
                                            input int x, input int y);
    int row, col, px, py, idx;
    logic [3:0] code;
    logic [14:0] a;
    if (x < BX0 || x >= BX0 + 8 * SQ) return BG;
    col = (x - BX0) / SQ;
    px  = (x - BX0) % SQ;
    row = y / SQ;
    py  = y % SQ;
    idx = row * 8 + col;
    code = b[4 * idx +: 4];
    a = {code[2:0] - 3'd1, 6'(py), 6'(px)};
    if (code[2:0] != 3'd0 && rom_bit(a)) return code[3] ? BLACK : WHITE;
`ifdef CURSOR_HIGHLIGHT_EN
    if (idx == int'(cur) && (px < 3 || px > SQ - 4 || py < 3 || py > SQ - 4)) return HL;
`else
    if (cur == 6'h3f && idx < 0) return HL;
`endif
    return ((row + col) % 2 == 0) ? LIGHT : DARK;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (fb_if.wr_en) begin
        wr_total++;
        if (int'(fb_if.wr_addr) < NPIX) fb_mem[fb_if.wr_addr] = fb_if.wr_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d data %06h, none expected",
                   fb_if.wr_addr, fb_if.wr_data);
        end else begin
          e = exp_q.pop_front();
          if (fb_if.wr_addr !== e.addr || fb_if.wr_data !== e.data) begin
            errors++;
            $display("FAIL pixel: got addr %0d data %06h, expected addr %0d data %06h",
                     fb_if.wr_addr, fb_if.wr_data, e.addr, e.data);
          end
        end
      end
      if (fb_if.done) begin
        done_count++;
        checks++;
        if (!prev_wr_en || exp_q.size() != 0 || fb_if.busy) begin
          errors++;
          $display("FAIL done_timing: prev_wr_en %0b pending %0d busy %0b, expected 1 0 0",
                   prev_wr_en, exp_q.size(), fb_if.busy);
        end
      end
      prev_wr_en = fb_if.wr_en;
    end else begin
      prev_wr_en = 1'b0;
    end
  end

  function automatic logic [255:0] rand_board();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32 * i +: 32] = $urandom;
    return b;
  endfunction

  task automatic push_frame(input logic [255:0] b, input logic [5:0] cur);
    exp_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.addr = 19'(y * W + x);
        e.data = ref_pixel(b, cur, x, y);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input logic [255:0] b, input logic [5:0] cur);
    @(negedge clk);
    fb_if.board     = b;
    fb_if.cursor_sq = cur;
    fb_if.start     = 1'b1;
    @(negedge clk);
    fb_if.start = 1'b0;
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < NPIX + 100; i++) begin
      @(negedge clk);
      if (fb_if.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_frame(input logic [255:0] b, input logic [5:0] cur, input bit perturb);
    int d0;
    d0 = done_count;
    push_frame(b, cur);
    pulse_start(b, cur);
    check("busy_after_start", 32'(fb_if.busy), 32'd1);
    if (perturb) begin
      repeat (2000) @(negedge clk);
      pulse_start(rand_board(), 6'($urandom_range(0, 63)));
    end
    wait_done();
    repeat (5) @(negedge clk);
    check("single_done", 32'(done_count - d0), 32'd1);
    check("frame_complete", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    fb_if.start     = 1'b0;
    fb_if.board     = '0;
    fb_if.cursor_sq = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("reset_idle", {fb_if.wr_en, fb_if.busy, fb_if.done, 10'd0, fb_if.wr_addr}, 32'd0);
    end

    // Empty board: margins and square colours at the board edges.
    rom_mode = 0;
    rom_hit  = {3'd5, 6'(SQ / 2), 6'(SQ / 2)};
    run_frame('0, 6'd0, 1'b0);
    check("empty_addr0", 32'(fb_mem[0]), 32'(BG));
    check("empty_left_edge", 32'(fb_mem[BX0]), 32'(LIGHT));
    check("empty_second_sq", 32'(fb_mem[BX0 + SQ]), 32'(DARK));
    check("empty_right_edge", 32'(fb_mem[BX0 + 8 * SQ - 1]), 32'(DARK));
    check("empty_right_margin", 32'(fb_mem[BX0 + 8 * SQ]), 32'(BG));

    // Kings at square 0, single mask bit at the square centre.
    run_frame(256'h6, 6'd0, 1'b0);
    check("white_king_px", 32'(fb_mem[(SQ / 2) * W + BX0 + SQ / 2]), 32'(WHITE));
    check("white_king_next", 32'(fb_mem[(SQ / 2) * W + BX0 + SQ / 2 + 1]), 32'(LIGHT));
    run_frame(256'hE, 6'd0, 1'b0);
    check("black_king_px", 32'(fb_mem[(SQ / 2) * W + BX0 + SQ / 2]), 32'(BLACK));

    // Random board with a busy-time start and board change.
    rom_mode = 1;
    rom_seed = $urandom;
    run_frame(rand_board(), 6'($urandom_range(0, 63)), 1'b1);

    // Reset part-way through a frame.
    push_frame(rand_board(), 6'd0);
    exp_q.delete();
    push_frame(fb_if.board, 6'd0);
    pulse_start(fb_if.board, 6'd0);
    base = wr_total;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wr_total - base >= 1000) break;
    end
    check("reached_1000_writes", 32'(wr_total - base >= 1000), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("reset_abort", {fb_if.wr_en, fb_if.busy, fb_if.done}, 32'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {fb_if.wr_en, fb_if.busy}, 32'd0);
    end
    reset_n = 1'b1;
    rom_seed = $urandom;
    run_frame(rand_board(), 6'($urandom_range(0, 63)), 1'b0);

    // Cursor on row 1, col 1.
    run_frame('0, 6'd9, 1'b0);
`ifdef CURSOR_HIGHLIGHT_EN
    check("cursor_ring", 32'(fb_mem[SQ * W + BX0 + SQ]), 32'(HL));
`else
    check("cursor_ring", 32'(fb_mem[SQ * W + BX0 + SQ]), 32'(LIGHT));
`endif
    check("cursor_centre", 32'(fb_mem[(SQ + SQ / 2) * W + BX0 + SQ + SQ / 2]), 32'(LIGHT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
